kbd_fifo: RTL and testbench
===========================

# kbd_fifo

Keyboard input buffer between the PS/2 scancode-to-ASCII decoder and the CPU data bus. It queues decoded ASCII bytes in a small synchronous FIFO so the CPU no longer loses keystrokes when it polls slowly. It exposes the queue as two memory-mapped words at KBD_BASE, and the top level muxes `rdata` onto `mem_read_data` whenever `hit` is high.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `KBD_BASE`, default 32'h2000: byte address of the DATA word; the CTRL word is at KBD_BASE+4.

- `clk`  in  1  system clock; shares the CPU clock `cs_clk`.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  decoder "key available" level or strobe; only its rising edge pushes.
- `in_data`  in  8  ASCII byte; sampled on the rising-edge cycle of `in_valid`.
- `cpu_addr`  in  32  CPU data address.
- `cpu_wren`  in  1  CPU store enable.
- `cpu_wdata`  in  32  CPU store data.
- `rdata`  out  32  read data for the addressed register; combinational.
- `hit`  out  1  high when `cpu_addr` equals KBD_BASE or KBD_BASE+4; combinational.
- `irq`  out  1  registered; high while the FIFO is non-empty.

## Operation
- **Edge detect.** `in_prev` is a register that takes `in_valid` every cycle. A push request is `in_valid & ~in_prev`, so a multi-cycle level counts as one key.
- **FIFO storage.** 2^DEPTH_LOG2 × 8 storage with `wptr` and `rptr`, each DEPTH_LOG2 bits and wrapping modulo depth. `count` is DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.
- **DATA word (KBD_BASE), read.** Returns {23'b0, nonempty, head}.
  - `head` is the byte at `rptr`, or 8'h00 when empty.
  - Reading does not pop; the CPU has no read strobe.
- **DATA word, write.** Ignored.
- **CTRL word (KBD_BASE+4), read.** Returns {22'b0, overflow, full, 3'b0, count[4:0]} for the default depth. For other depths, `count` stays at bits [DEPTH_LOG2:0].
- **CTRL word, write.** Acts when `cpu_wren` is high.
  - bit0 = pop: advance `rptr` if non-empty.
  - bit1 = clear `overflow`.
  - bit2 = flush: `rptr` = `wptr` = `count` = 0.
  - Multiple bits in one write are allowed.
- **Unaddressed reads.** `rdata` = 0 when `hit` = 0.
- **Simultaneous push and pop, non-empty FIFO.** Both take effect; `count` is unchanged. This also holds when full: the pop frees a slot, the push is accepted, and `overflow` is not set.
- **Simultaneous push and pop, empty FIFO.** The push takes effect and the pop is ignored.
- **Push when full, no pop.** The byte is dropped and `overflow` is set to 1. It stays set until cleared.
- **Pop when empty.** No effect.
- **Flush together with a push in the same cycle.** Flush wins, the byte is dropped, and `overflow` is not set.
- **Overflow set and clear in the same cycle.** Set wins.
- **Reset, asserted at any time.** Reset values:
  - `wptr`, `rptr`, `count`, `overflow`, `irq`: 0.
  - `in_prev`: 1, so a level already high at reset release does not push.
  - Storage contents are not reset.

## Timing
- **Push latency.** A push requested in cycle N is written at the end of cycle N. From cycle N+1:
  - `count` and `nonempty` reflect the push.
  - `rdata` reflects the push combinationally.
  - `irq` rises at the end of N+1, one cycle after `nonempty`.
- **Pop latency.** A pop write in cycle N changes `head` and `count` from cycle N+1.
- **Throughput.** One push and one pop per cycle sustained.
- **Bus path.** `rdata` and `hit` are combinational from `cpu_addr` and registered state. The path is one compare plus a mux, with no added latency on the CPU read path.
- **Clock-domain boundary.** `in_valid` and `in_data` must be synchronous to `clk`. Synchronisation from the PS/2 clock domain is the decoder's responsibility.

## Structure
- **Package `kbd_pkg`:**
  - register offsets: DATA_OFS = 0, CTRL_OFS = 4;
  - CTRL bit positions: POP = 0, CLR_OVF = 1, FLUSH = 2, STAT_FULL = 8, STAT_OVF = 9;
  - DATA nonempty bit = 8.
- **Sub-module `sync_fifo`:** parameterised by width and DEPTH_LOG2, with ports `push`, `pop`, `flush`, `din`, `dout`, `count`, `full`, `empty`. The same reset convention applies.
- **Top level of `kbd_fifo`:** edge detect, address decode, `overflow`/`irq` registers and the read mux.

## Test plan
- **Reset and empty reads.** Reset, then read KBD_BASE and KBD_BASE+4 → both 32'h0; `irq` = 0; `hit` = 1 for each; `hit` = 0 and `rdata` = 0 at 32'h2008.
- **Order and edge detect.** Push 'A' (8'h41) then 'B' (8'h42), holding `in_valid` 3 cycles each → count = 2. DATA = 32'h141. Pop → DATA = 32'h142. Pop → DATA = 0, `irq` falls.
- **Fill and overflow.** Push 17 distinct bytes with no pops → count = 16, full = 1, overflow = 1 (CTRL = 32'h310). Head = first byte. Write 32'h2 → CTRL = 32'h110.
- **Full FIFO, push and pop together.** Full FIFO, push and pop in the same cycle → count stays 16, overflow stays 0. After 16 pops, the last byte read is the newly pushed one, confirming pointer wrap.
- **Flush versus push.** Flush in the same cycle as a push → count = 0, overflow = 0.
- **Reset mid-traffic.** Assert `rst` low mid-stream with count = 5 and `in_valid` high → all outputs 0. After release with `in_valid` still high → no push until `in_valid` falls and rises again.

Source files
------------

// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_pkg
// Description : Shared constants for the keyboard input FIFO.
//               - Register offsets from KBD_BASE.
//               - CTRL command and status bit positions.
//               - DATA status bit position.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

  // Register offsets from KBD_BASE
  localparam logic [31:0] DATA_OFS = 32'h0;
  localparam logic [31:0] CTRL_OFS = 32'h4;

  // CTRL write command bits
  localparam int CTRL_POP     = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_FLUSH   = 2;

  // CTRL read status bits (count occupies bits [DEPTH_LOG2:0])
  localparam int STAT_FULL = 8;
  localparam int STAT_OVF  = 9;

  // DATA read: head byte in [7:0], nonempty flag here
  localparam int DATA_NONEMPTY = 8;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word-fall-through output.
//               dout always shows the entry at the read pointer.
// Ports       : clk, rst (async, active-low)
//               push, pop, flush - requests; flush overrides push and pop
//               din   - write data
//               dout  - head entry (undefined when empty)
//               count - occupancy, 0..2^DEPTH_LOG2
//               full, empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_COUNT);
  assign count = cnt;
  assign dout  = mem[rptr];

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/kbd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kbd_fifo
// Description : Keyboard ASCII buffer between the scancode decoder and the
//               CPU data bus. Exposes the queue as two memory-mapped words:
//               KBD_BASE+0 DATA  read {23'b0, nonempty, head}, writes ignored
//               KBD_BASE+4 CTRL  read {overflow, full, count}
//                                write bit0 pop, bit1 clr ovf, bit2 flush
// Ports       : clk, rst (async, active-low)
//               in_valid, in_data  - decoder byte; rising edge pushes
//               cpu_addr, cpu_wren, cpu_wdata - CPU data bus
//               rdata, hit         - combinational read data / address match
//               irq                - registered, high while FIFO non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] KBD_BASE   = 32'h2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_wren,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  localparam logic [31:0] DATA_ADDR = KBD_BASE + DATA_OFS;
  localparam logic [31:0] CTRL_ADDR = KBD_BASE + CTRL_OFS;

  logic                in_prev;
  logic                push_req;
  logic                sel_data;
  logic                sel_ctrl;
  logic                ctrl_wr;
  logic                pop_req;
  logic                clr_req;
  logic                flush_req;
  logic                overflow;
  logic                ovf_set;
  logic [7:0]          dout;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                empty;
  logic                unused_wdata;

  // Only the rising edge of in_valid counts as a key.
  assign push_req = in_valid & ~in_prev;

  assign sel_data = (cpu_addr == DATA_ADDR);
  assign sel_ctrl = (cpu_addr == CTRL_ADDR);
  assign hit      = sel_data | sel_ctrl;

  assign ctrl_wr   = cpu_wren & sel_ctrl;
  assign pop_req   = ctrl_wr & cpu_wdata[CTRL_POP];
  assign clr_req   = ctrl_wr & cpu_wdata[CTRL_CLR_OVF];
  assign flush_req = ctrl_wr & cpu_wdata[CTRL_FLUSH];

  assign unused_wdata = ^cpu_wdata[31:3];

  // Drop only when no slot frees up this cycle; a flush discards silently.
  assign ovf_set = push_req & full & ~pop_req & ~flush_req;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .flush (flush_req),
    .din   (in_data),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // in_prev resets high so a level already asserted at release is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_prev  <= 1'b1;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      in_prev <= in_valid;
      irq     <= ~empty;
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_req) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_data) begin
      rdata[7:0]           = empty ? 8'h00 : dout;
      rdata[DATA_NONEMPTY] = ~empty;
    end else if (sel_ctrl) begin
      rdata[DEPTH_LOG2:0] = count;
      rdata[STAT_FULL]    = full;
      rdata[STAT_OVF]     = overflow;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_fifo
// Description : Scoreboard bench for kbd_fifo. Stimulus queues the expected
//               bus read result; a monitor compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_fifo;

  localparam logic [31:0] DATA_A = 32'h2000;
  localparam logic [31:0] CTRL_A = 32'h2004;
  localparam logic [31:0] NONE_A = 32'h2008;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [31:0] cpu_addr;
  logic        cpu_wren;
  logic [31:0] cpu_wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  logic mon_req = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  kbd_fifo #(
    .DEPTH_LOG2 (4),
    .KBD_BASE   (32'h2000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cpu_addr  (cpu_addr),
    .cpu_wren  (cpu_wren),
    .cpu_wdata (cpu_wdata),
    .rdata     (rdata),
    .hit       (hit),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Monitor: one comparison per queued expectation.
  always @(negedge clk) begin
    if (mon_req) begin
      n_tests = n_tests + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL scoreboard: read presented with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rdata !== e.rdata || hit !== e.hit || irq !== e.irq) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: rdata=%h hit=%b irq=%b, expected rdata=%h hit=%b irq=%b",
                   e.name, rdata, hit, irq, e.rdata, e.hit, e.irq);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [31:0] addr, input logic [31:0] exp_rd,
                       input logic exp_hit, input logic exp_irq, input string name);
    exp_t e;
    e.name  = name;
    e.rdata = exp_rd;
    e.hit   = exp_hit;
    e.irq   = exp_irq;
    cpu_addr = addr;
    exp_q.push_back(e);
    mon_req = 1'b1;
    cyc();
    mon_req  = 1'b0;
    cpu_addr = 32'h0;
  endtask

  task automatic key(input logic [7:0] b, input int hold);
    in_valid = 1'b1;
    in_data  = b;
    repeat (hold) cyc();
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] val);
    cpu_addr  = addr;
    cpu_wren  = 1'b1;
    cpu_wdata = val;
    cyc();
    cpu_wren  = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
  endtask

  // Key rising edge and CTRL write in the same cycle.
  task automatic key_and_ctrl(input logic [7:0] b, input logic [31:0] val);
    in_valid  = 1'b1;
    in_data   = b;
    cpu_addr  = CTRL_A;
    cpu_wren  = 1'b1;
    cpu_wdata = val;
    cyc();
    in_valid  = 1'b0;
    cpu_wren  = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    cpu_addr  = 32'h0;
    cpu_wren  = 1'b0;
    cpu_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();

    // Reset and empty reads
    check(DATA_A, 32'h0, 1'b1, 1'b0, "reset_data");
    check(CTRL_A, 32'h0, 1'b1, 1'b0, "reset_ctrl");
    check(NONE_A, 32'h0, 1'b0, 1'b0, "unmapped");

    // Order and edge detect; DATA writes ignored
    key(8'h41, 3);
    key(8'h42, 3);
    wr(DATA_A, 32'h7);
    check(CTRL_A, 32'h002, 1'b1, 1'b1, "count_two");
    check(DATA_A, 32'h141, 1'b1, 1'b1, "head_A");
    wr(CTRL_A, 32'h1);
    check(DATA_A, 32'h142, 1'b1, 1'b1, "head_B");
    wr(CTRL_A, 32'h1);
    check(DATA_A, 32'h000, 1'b1, 1'b1, "empty_irq_lag");
    check(DATA_A, 32'h000, 1'b1, 1'b0, "irq_fall");

    // Fill and overflow
    for (int i = 0; i < 17; i++) key(8'h10 + 8'(i), 1);
    check(CTRL_A, 32'h310, 1'b1, 1'b1, "full_ovf");
    check(DATA_A, 32'h110, 1'b1, 1'b1, "full_head");
    wr(CTRL_A, 32'h2);
    check(CTRL_A, 32'h110, 1'b1, 1'b1, "ovf_clear");

    // Full FIFO, push and pop together, then drain through the wrap
    key_and_ctrl(8'h55, 32'h1);
    check(CTRL_A, 32'h110, 1'b1, 1'b1, "full_push_pop");
    check(DATA_A, 32'h111, 1'b1, 1'b1, "head_after_pp");
    repeat (15) wr(CTRL_A, 32'h1);
    check(DATA_A, 32'h155, 1'b1, 1'b1, "wrap_last");
    check(CTRL_A, 32'h001, 1'b1, 1'b1, "wrap_count");
    wr(CTRL_A, 32'h1);
    check(CTRL_A, 32'h000, 1'b1, 1'b1, "drained");

    // Pop when empty
    wr(CTRL_A, 32'h1);
    check(CTRL_A, 32'h000, 1'b1, 1'b0, "pop_empty");
    check(DATA_A, 32'h000, 1'b1, 1'b0, "pop_empty_data");

    // Overflow set and clear together; flush versus push when full
    for (int i = 0; i < 16; i++) key(8'h30 + 8'(i), 1);
    check(CTRL_A, 32'h110, 1'b1, 1'b1, "refill");
    check(DATA_A, 32'h130, 1'b1, 1'b1, "refill_head");
    key_and_ctrl(8'h99, 32'h2);
    check(CTRL_A, 32'h310, 1'b1, 1'b1, "set_beats_clear");
    key_and_ctrl(8'hAA, 32'h4);
    check(CTRL_A, 32'h200, 1'b1, 1'b0, "flush_full_push");
    wr(CTRL_A, 32'h2);
    check(CTRL_A, 32'h000, 1'b1, 1'b0, "ovf_clear2");

    // Flush versus push, partly filled
    key(8'h61, 1);
    key(8'h62, 1);
    check(CTRL_A, 32'h002, 1'b1, 1'b1, "pre_flush");
    key_and_ctrl(8'h63, 32'h4);
    check(CTRL_A, 32'h000, 1'b1, 1'b0, "flush_push");
    check(DATA_A, 32'h000, 1'b1, 1'b0, "flush_data");

    // Reset mid-traffic
    for (int i = 0; i < 5; i++) key(8'h71 + 8'(i), 1);
    check(CTRL_A, 32'h005, 1'b1, 1'b1, "pre_reset");
    in_valid = 1'b1;
    in_data  = 8'h76;
    rst      = 1'b0;
    #1;
    check(CTRL_A, 32'h000, 1'b1, 1'b0, "in_reset_ctrl");
    check(DATA_A, 32'h000, 1'b1, 1'b0, "in_reset_data");
    rst = 1'b1;
    cyc();
    cyc();
    check(CTRL_A, 32'h000, 1'b1, 1'b0, "level_held");
    in_valid = 1'b0;
    cyc();
    key(8'h76, 1);
    check(CTRL_A, 32'h001, 1'b1, 1'b1, "repush_count");
    check(DATA_A, 32'h176, 1'b1, 1'b1, "repush_data");

    cyc();
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
